vga_pixel_fetch: RTL

Frame-buffer reader feeding the VGA colour path. Fetches 12-bit pixel words from an external frame-buffer memory over a req/ack port, buffers them in a small prefetch FIFO, and presents one word on `Data` per display-region pixel. `Data` is aligned with the registered active flag of the colour-assignment stage, so it lags the pixel counters by one cycle. Sits between the frame-buffer memory and the colour-assignment stage, driven by the same horizontal/vertical counters and margin registers from the Config unit.

---
 rtl/vga_pixel_fetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vga_pixel_fetch.sv
// Frame-buffer prefetch reader: fetches pixel words over req/ack into a small FIFO
// and presents one word per display pixel. Optional underrun colour/flag: VGA_FETCH_UNDERRUN_EN.
module vga_pixel_fetch #(
  parameter int DATA_WIDTH    = 12,
  parameter int REZ_MAX_WIDTH = 11,
  parameter int ADDR_WIDTH    = 19,
  parameter int FIFO_DEPTH    = 8,
  parameter logic [DATA_WIDTH-1:0] UNDERRUN_COLOR = 12'hF0F
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [REZ_MAX_WIDTH-1:0]         Count_h,
  input  logic [REZ_MAX_WIDTH-1:0]         Count_v,
  input  logic [REZ_MAX_WIDTH-1:0]         H_left_margin,
  input  logic [REZ_MAX_WIDTH-1:0]         H_right_margin,
  input  logic [REZ_MAX_WIDTH-1:0]         V_left_margin,
  input  logic [REZ_MAX_WIDTH-1:0]         V_right_margin,
  output logic                             Mem_req,
  output logic [ADDR_WIDTH-1:0]            Mem_addr,
  input  logic                             Mem_ack,
  input  logic [DATA_WIDTH-1:0]            Mem_rdata,
  output logic [DATA_WIDTH-1:0]            Data,
  output logic [$clog2(FIFO_DEPTH):0]      Fifo_level,
  output logic                             Underrun
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
`ifdef VGA_FETCH_UNDERRUN_EN
  localparam bit UNDERRUN_EN = 1'b1;
`else
  localparam bit UNDERRUN_EN = 1'b0;
`endif
  localparam logic [DATA_WIDTH-1:0] EMPTY_WORD = UNDERRUN_EN ? UNDERRUN_COLOR : '0;

  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

  state_t                  state, state_nxt;
  logic                    flush_pend;
  logic                    push, pop, pop_req, flush_done, empty;
  logic                    active, frame_start;
  logic [ADDR_WIDTH-1:0]   h_span, v_span, frame_pixels_c, frame_pixels, addr;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [LW-1:0]           level;
  logic                    room_idle, room_req, addr_ok_idle, addr_ok_req;

  assign active = (Count_h >= H_left_margin) && (Count_h <= H_right_margin) &&
                  (Count_v >= V_left_margin) && (Count_v <= V_right_margin);
  assign frame_start = (Count_h == '0) && (Count_v == '0);

  assign h_span = ADDR_WIDTH'(H_right_margin) - ADDR_WIDTH'(H_left_margin) + ADDR_WIDTH'(1);
  assign v_span = ADDR_WIDTH'(V_right_margin) - ADDR_WIDTH'(V_left_margin) + ADDR_WIDTH'(1);
  assign frame_pixels_c = h_span * v_span;

  assign empty   = (level == '0);
  assign pop_req = active && !frame_start;
  assign pop     = pop_req && !empty;

  // While in REQ the outstanding request already claims one FIFO slot and one address.
  assign room_idle    = level < LW'(FIFO_DEPTH);
  assign room_req     = level < LW'(FIFO_DEPTH - 1);
  assign addr_ok_idle = addr < frame_pixels;
  assign addr_ok_req  = (addr + ADDR_WIDTH'(1)) < frame_pixels;

  assign Mem_req    = (state == REQ) || ((state == FLUSH) && flush_pend);
  assign Mem_addr   = addr;
  assign Fifo_level = level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (frame_start)  flush_pend <= Mem_req && !Mem_ack;
      else if (Mem_ack) flush_pend <= 1'b0;
    end
  end

  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    flush_done = 1'b0;
    unique case (state)
      IDLE: if (room_idle && addr_ok_idle) state_nxt = REQ;
      REQ: if (Mem_ack) begin
        push      = 1'b1;
        state_nxt = (room_req && addr_ok_req) ? REQ : IDLE;
      end
      FLUSH: if (!flush_pend || Mem_ack) begin
        flush_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A new frame overrides everything; any in-flight ack is dropped.
    if (frame_start) begin
      state_nxt  = FLUSH;
      push       = 1'b0;
      flush_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_pixels <= '0;
      addr         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      Data         <= '0;
    end else begin
      if (frame_start) frame_pixels <= frame_pixels_c;
      if (flush_done)  addr <= '0;
      else if (push)   addr <= addr + ADDR_WIDTH'(1);
      if (frame_start || flush_done) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        level <= level + LW'(push) - LW'(pop);
      end
      Data <= pop_req ? (empty ? EMPTY_WORD : fifo_mem[rd_ptr]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= Mem_rdata;
  end

`ifdef VGA_FETCH_UNDERRUN_EN
  logic underrun_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                underrun_q <= 1'b0;
    else if (frame_start)      underrun_q <= 1'b0;
    else if (pop_req && empty) underrun_q <= 1'b1;
  end
  assign Underrun = underrun_q;
`else
  assign Underrun = 1'b0;
`endif

endmodule
